// File: rtl/pll_rst_pkg.sv
// Shared types and elaboration helpers for the PLL reset sequencer.
// Latency: none (types/constants only). Backpressure: not applicable.
// Holds the FSM state encoding and the dwell counter width calculation.
package pll_rst_pkg;

   typedef enum logic [2:0] {
      PLL_RST   = 3'd0,
      WAIT_LOCK = 3'd1,
      STABLE    = 3'd2,
      RELEASE   = 3'd3,
      RUN       = 3'd4
   } seq_state_t;

   function automatic int max4(input int a, input int b, input int c, input int d);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return m;
   endfunction

   function automatic int clog2_int(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r = r + 1;
      return r;
   endfunction

   // One spare bit so the largest terminal count always fits.
   function automatic int dwell_width(input int a, input int b, input int c, input int d);
      return clog2_int(max4(a, b, c, d)) + 1;
   endfunction

endpackage

// File: rtl/bit_synchronizer.sv
// Two-flop synchronizer for a single asynchronous level, resets to 0.
// Latency: 2 clk cycles. Backpressure: none, free-running.
// Used to bring the PLL locked indication into the refclk domain.
module bit_synchronizer (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL bring-up: pulses pll_areset, qualifies lock, releases staggered resets; PLL_RELOCK_CNT_EN adds relock_count.
// Latency: outputs registered, one cycle after the deciding edge; locked adds 2 sync cycles.
// Backpressure: none; sw_reset_req is a single-cycle pulse sampled every edge.
module pll_reset_sequencer
   import pll_rst_pkg::*;
#(
   parameter int NUM_RST             = 2,
   parameter int PLL_RST_CYCLES      = 16,
   parameter int LOCK_STABLE_CYCLES  = 1024,
   parameter int STAGGER_CYCLES      = 8,
   parameter int LOCK_TIMEOUT_CYCLES = 1000000,
   parameter int CNT_W               = 8
) (
   input  logic               refclk,
   input  logic               rst_n,
   input  logic               pll_locked,
   input  logic               sw_reset_req,
   output logic               pll_areset,
   output logic [NUM_RST-1:0] rst_out_n,
   output logic               sys_ready,
   output logic [2:0]         state,
   output logic [CNT_W-1:0]   relock_count
);

   localparam int DW = dwell_width(PLL_RST_CYCLES, LOCK_STABLE_CYCLES,
                                   NUM_RST * STAGGER_CYCLES + 1, LOCK_TIMEOUT_CYCLES);

   localparam logic [DW-1:0] RST_LAST = DW'(PLL_RST_CYCLES - 1);
   localparam logic [DW-1:0] TMO_LAST = DW'(LOCK_TIMEOUT_CYCLES - 1);
   localparam logic [DW-1:0] STB_LAST = DW'(LOCK_STABLE_CYCLES - 1);
   localparam logic [DW-1:0] REL_LAST = DW'(NUM_RST * STAGGER_CYCLES);

   logic               locked_s;
   seq_state_t         state_q, state_d;
   logic [DW-1:0]      cnt_q, cnt_d;
   logic               areset_d;
   logic               ready_d;
   logic [NUM_RST-1:0] rst_d;

   bit_synchronizer u_lock_sync (
      .clk   (refclk),
      .rst_n (rst_n),
      .d     (pll_locked),
      .q     (locked_s)
   );

   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= PLL_RST;
         cnt_q      <= '0;
         pll_areset <= 1'b1;
         rst_out_n  <= '0;
         sys_ready  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         pll_areset <= areset_d;
         rst_out_n  <= rst_d;
         sys_ready  <= ready_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         PLL_RST:   if (cnt_q == RST_LAST) state_d = WAIT_LOCK;
         WAIT_LOCK: begin
            if (locked_s)                state_d = STABLE;
            else if (cnt_q == TMO_LAST)  state_d = PLL_RST;
         end
         STABLE: begin
            if (!locked_s)               state_d = WAIT_LOCK;
            else if (cnt_q == STB_LAST)  state_d = RELEASE;
         end
         RELEASE: begin
            if (!locked_s)               state_d = WAIT_LOCK;
            else if (cnt_q == REL_LAST)  state_d = RUN;
         end
         RUN:       if (!locked_s) state_d = WAIT_LOCK;
         default:   state_d = PLL_RST;
      endcase
      // Software re-sequence wins over everything, including a coincident lock loss.
      if (sw_reset_req && state_q != PLL_RST) state_d = PLL_RST;
   end

   // Dwell counter restarts on every transition and idles in RUN.
   assign cnt_d = (state_d != state_q || state_q == RUN) ? '0 : cnt_q + DW'(1);

   always_comb begin
      areset_d = (state_d == PLL_RST);
      ready_d  = (state_d == RUN);
      rst_d    = '0;
      if (state_d == RUN) begin
         rst_d = '1;
      end else if (state_d == RELEASE && state_q == RELEASE) begin
         // Thresholds rise with i and cnt only climbs, so release order is fixed.
         for (int i = 0; i < NUM_RST; i++)
            rst_d[i] = (cnt_q >= DW'((i + 1) * STAGGER_CYCLES - 1));
      end
   end

   assign state = state_q;

`ifdef PLL_RELOCK_CNT_EN
   logic             relock_hit;
   logic [CNT_W-1:0] relock_q;

   assign relock_hit = (state_q == RELEASE || state_q == RUN) && !locked_s && !sw_reset_req;

   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n)
         relock_q <= '0;
      else if (relock_hit && relock_q != {CNT_W{1'b1}})
         relock_q <= relock_q + CNT_W'(1);
   end

   assign relock_count = relock_q;
`else
   assign relock_count = '0;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer: vector table plus timeout, async reset and saturation sequences.
module tb_pll_reset_sequencer;

   localparam int NUM_RST = 3;
   localparam int CNT_W   = 8;

   logic               refclk = 1'b0;
   logic               rst_n = 1'b0;
   logic               pll_locked = 1'b0;
   logic               sw_reset_req = 1'b0;
   logic               pll_areset;
   logic [NUM_RST-1:0] rst_out_n;
   logic               sys_ready;
   logic [2:0]         state;
   logic [CNT_W-1:0]   relock_count;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   always #5 refclk = ~refclk;

   pll_reset_sequencer #(
      .NUM_RST             (NUM_RST),
      .PLL_RST_CYCLES      (4),
      .LOCK_STABLE_CYCLES  (8),
      .STAGGER_CYCLES      (2),
      .LOCK_TIMEOUT_CYCLES (32),
      .CNT_W               (CNT_W)
   ) dut (
      .refclk       (refclk),
      .rst_n        (rst_n),
      .pll_locked   (pll_locked),
      .sw_reset_req (sw_reset_req),
      .pll_areset   (pll_areset),
      .rst_out_n    (rst_out_n),
      .sys_ready    (sys_ready),
      .state        (state),
      .relock_count (relock_count)
   );

   typedef struct {
      int         cyc;
      logic       lock;
      logic       req;
      logic       areset;
      logic [2:0] rst;
      logic       rdy;
      logic [2:0] st;
      int         rl;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input int c, input logic lk, input logic rq, input logic ar,
                      input logic [2:0] r, input logic rd, input logic [2:0] s, input int rl);
      vec_t v;
      v.cyc = c; v.lock = lk; v.req = rq; v.areset = ar;
      v.rst = r; v.rdy = rd; v.st = s; v.rl = rl;
      vecs.push_back(v);
   endtask

   function automatic int exp_rl(input int n);
`ifdef PLL_RELOCK_CNT_EN
      return (n > 255) ? 255 : n;
`else
      return (n > 0) ? 0 : n;
`endif
   endfunction

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s cyc=%0d actual=%0d expected=%0d", name, cyc, act, exp);
      end
   endtask

   task automatic check_all(input string name, input logic ar, input logic [2:0] r,
                            input logic rd, input logic [2:0] s, input int rl);
      check({name, ".pll_areset"},   int'(pll_areset),   int'(ar));
      check({name, ".rst_out_n"},    int'(rst_out_n),    int'(r));
      check({name, ".sys_ready"},    int'(sys_ready),    int'(rd));
      check({name, ".state"},        int'(state),        int'(s));
      check({name, ".relock_count"}, int'(relock_count), exp_rl(rl));
   endtask

   task automatic step();
      @(posedge refclk);
      #1;
      cyc++;
   endtask

   // Entered and left at a falling edge so state is sampled mid-cycle.
   task automatic wait_state(input logic [2:0] target, input int budget, input string name);
      int n;
      n = 0;
      while (state != target && n < budget) begin
         step();
         @(negedge refclk);
         n++;
      end
      check(name, int'(state), int'(target));
   endtask

   initial begin
      // cyc lock req areset rst rdy st rl  (lock/req applied from that cycle on)
      add( 0, 0, 0, 1, 3'b000, 0, 0, 0);
      add( 3, 0, 0, 1, 3'b000, 0, 0, 0);
      add( 4, 0, 0, 0, 3'b000, 0, 1, 0);
      add(10, 1, 0, 0, 3'b000, 0, 1, 0);
      add(12, 1, 0, 0, 3'b000, 0, 1, 0);
      add(13, 1, 0, 0, 3'b000, 0, 2, 0);
      add(20, 1, 0, 0, 3'b000, 0, 2, 0);
      add(21, 1, 0, 0, 3'b000, 0, 3, 0);
      add(22, 1, 0, 0, 3'b000, 0, 3, 0);
      add(23, 1, 0, 0, 3'b001, 0, 3, 0);
      add(24, 1, 0, 0, 3'b001, 0, 3, 0);
      add(25, 1, 0, 0, 3'b011, 0, 3, 0);
      add(27, 1, 0, 0, 3'b111, 0, 3, 0);
      add(28, 1, 0, 0, 3'b111, 1, 4, 0);
      // lock drop for one cycle while running
      add(30, 0, 0, 0, 3'b111, 1, 4, 0);
      add(31, 1, 0, 0, 3'b111, 1, 4, 0);
      add(32, 1, 0, 0, 3'b111, 1, 4, 0);
      add(33, 1, 0, 0, 3'b000, 0, 1, 1);
      add(34, 1, 0, 0, 3'b000, 0, 2, 1);
      add(42, 1, 0, 0, 3'b000, 0, 3, 1);
      add(44, 1, 0, 0, 3'b001, 0, 3, 1);
      add(48, 1, 0, 0, 3'b111, 0, 3, 1);
      add(49, 1, 0, 0, 3'b111, 1, 4, 1);
      // software request coincident with locked_s falling
      add(52, 0, 0, 0, 3'b111, 1, 4, 1);
      add(53, 1, 0, 0, 3'b111, 1, 4, 1);
      add(54, 1, 1, 0, 3'b111, 1, 4, 1);
      add(55, 1, 0, 1, 3'b000, 0, 0, 1);
      add(58, 1, 0, 1, 3'b000, 0, 0, 1);
      add(59, 1, 0, 0, 3'b000, 0, 1, 1);
      add(60, 1, 0, 0, 3'b000, 0, 2, 1);
      // glitch at dwell count 5 in STABLE
      add(63, 0, 0, 0, 3'b000, 0, 2, 1);
      add(64, 1, 0, 0, 3'b000, 0, 2, 1);
      add(65, 1, 0, 0, 3'b000, 0, 2, 1);
      add(66, 1, 0, 0, 3'b000, 0, 1, 1);
      add(67, 1, 0, 0, 3'b000, 0, 2, 1);
      add(74, 1, 0, 0, 3'b000, 0, 2, 1);
      add(75, 1, 0, 0, 3'b000, 0, 3, 1);
      add(77, 1, 0, 0, 3'b001, 0, 3, 1);
      add(82, 1, 0, 0, 3'b111, 1, 4, 1);

      #12;
      check_all("reset", 1'b1, 3'b000, 1'b0, 3'd0, 0);

      @(posedge refclk);
      #1;
      rst_n = 1'b1;
      cyc = 0;

      foreach (vecs[k]) begin
         while (cyc < vecs[k].cyc) step();
         pll_locked   = vecs[k].lock;
         sw_reset_req = vecs[k].req;
         @(negedge refclk);
         check_all($sformatf("vec%0d", k), vecs[k].areset, vecs[k].rst,
                   vecs[k].rdy, vecs[k].st, vecs[k].rl);
      end

      // asynchronous reset from RUN
      step();
      rst_n = 1'b0;
      pll_locked = 1'b0;
      #1;
      check_all("async_rst", 1'b1, 3'b000, 1'b0, 3'd0, 0);

      // no lock: PLL reset re-pulses every 4+32 cycles
      @(posedge refclk);
      #1;
      rst_n = 1'b1;
      cyc = 0;
      for (int c = 0; c < 76; c++) begin
         logic ar;
         @(negedge refclk);
         ar = ((c % 36) < 4);
         check("tmo.pll_areset", int'(pll_areset), int'(ar));
         check("tmo.state", int'(state), ar ? 0 : 1);
         check("tmo.rst_out_n", int'(rst_out_n), 0);
         step();
      end

      // relock counter saturation
      pll_locked = 1'b1;
      @(negedge refclk);
      wait_state(3'd4, 100, "sat.reach_run");
      for (int i = 0; i < 300; i++) begin
         step();
         pll_locked = 1'b0;
         step();
         pll_locked = 1'b1;
         @(negedge refclk);
         wait_state(3'd1, 10, "sat.loss_seen");
         check("sat.relock_count", int'(relock_count), exp_rl(i + 1));
         check("sat.rst_out_n", int'(rst_out_n), 0);
         wait_state(3'd3, 40, "sat.reach_release");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
